pipelined_lookahead_subtractor: RTL and testbench



---
 rtl/adder_pkg.sv | 19 +
 rtl/lookahead_half_adder.sv | 48 ++++
 rtl/pipelined_lookahead_subtractor.sv | 136 +++++++++++++
 tb/tb_pipelined_lookahead_subtractor.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the registered lookahead adder/subtractor blocks.
//   DEFAULT_WIDTH   : default operand width of the datapaths
//   sub_overflow()  : two's-complement overflow of a - b from the sign bits
// ---------------------------------------------------------------------------
package adder_pkg;

    localparam int DEFAULT_WIDTH = 64;

    // A subtraction overflows only when the operands have different signs
    // and the result's sign differs from the minuend's.
    function automatic logic sub_overflow(input logic a_msb,
                                          input logic b_msb,
                                          input logic diff_msb);
        return (a_msb ^ b_msb) & (diff_msb ^ a_msb);
    endfunction

endpackage

// File: rtl/lookahead_half_adder.sv
// ---------------------------------------------------------------------------
// lookahead_half_adder
// N-bit carry-lookahead adder built on a parallel-prefix (Kogge-Stone)
// generate/propagate tree.
//   a, b  : addends (N bits)
//   cin   : carry in
//   sum   : a + b + cin, modulo 2^N
//   cout  : carry out of bit N-1
// ---------------------------------------------------------------------------
module lookahead_half_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int LEVELS = (N > 1) ? $clog2(N) : 1;

    // Group generate/propagate per prefix level; level L covers spans of 2^L bits.
    logic [N-1:0] gk [0:LEVELS];
    logic [N-1:0] pk [0:LEVELS];
    logic [N:0]   carry;

    assign gk[0] = a & b;
    assign pk[0] = a ^ b;

    genvar l;
    generate
        for (l = 0; l < LEVELS; l++) begin : g_prefix
            localparam int DIST = 1 << l;
            // Bits below DIST already hold their full prefix; the low mask keeps
            // their propagate intact so the carry-in can still ripple through.
            localparam logic [N-1:0] LOW_MASK = {N{1'b1}} >> (N - DIST);
            assign gk[l+1] = gk[l] | (pk[l] & (gk[l] << DIST));
            assign pk[l+1] = pk[l] & ((pk[l] << DIST) | LOW_MASK);
        end
    endgenerate

    // Carry into bit i+1 = prefix generate of bits [i:0], or the carry-in
    // propagated through all of them.
    assign carry = {gk[LEVELS] | (pk[LEVELS] & {N{cin}}), cin};
    assign sum   = pk[0] ^ carry[N-1:0];
    assign cout  = carry[N];

endmodule

// File: rtl/pipelined_lookahead_subtractor.sv
// ---------------------------------------------------------------------------
// pipelined_lookahead_subtractor
// Three-stage pipelined subtractor: diff = a - b - bin, computed as
// a + ~b + ~bin with the carry chain split into two registered lookahead halves.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, bin)
//   out_valid / out_ready: result handshake (diff, bout, ovf)
//   diff                 : a - b - bin modulo 2^WIDTH
//   bout                 : borrow out (unsigned a < b + bin)
//   ovf                  : two's-complement overflow
// ---------------------------------------------------------------------------
module pipelined_lookahead_subtractor
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int HALF = WIDTH / 2;

    // Stage 1 registers
    logic [WIDTH-1:0] a1, b1;
    logic             bin1, v1;

    // Stage 2 registers
    logic [HALF-1:0]  d_lo2, a_hi2, nb_hi2;
    logic             c2, a_msb2, b_msb2, v2;

    // Stage 3 registers
    logic             v3;

    logic             load1, load2, load3;
    logic [HALF-1:0]  lo_sum, hi_sum;
    logic             lo_cout, hi_cout;

    // Back-pressure ripples from the output towards the input within one
    // cycle, so a full pipe can shift every stage on the edge out_ready rises.
    assign load3     = v2 & (~v3 | out_ready);
    assign load2     = v1 & (~v2 | load3);
    assign in_ready  = ~v1 | load2;
    assign load1     = in_valid & in_ready;
    assign out_valid = v3;

    // Low half: subtraction as addition of the inverted subtrahend, with the
    // inverted borrow-in as carry-in.
    lookahead_half_adder #(.N(HALF)) u_lo (
        .a    (a1[HALF-1:0]),
        .b    (~b1[HALF-1:0]),
        .cin  (~bin1),
        .sum  (lo_sum),
        .cout (lo_cout)
    );

    // High half: continues from the carry registered between the halves.
    lookahead_half_adder #(.N(HALF)) u_hi (
        .a    (a_hi2),
        .b    (nb_hi2),
        .cin  (c2),
        .sum  (hi_sum),
        .cout (hi_cout)
    );

    // Stage valid bits: set on load, cleared when drained without refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (load1)      v1 <= 1'b1;
            else if (load2) v1 <= 1'b0;
            if (load2)      v2 <= 1'b1;
            else if (load3) v2 <= 1'b0;
            if (load3)          v3 <= 1'b1;
            else if (out_ready) v3 <= 1'b0;
        end
    end

    // Stage 1: operand capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1   <= '0;
            b1   <= '0;
            bin1 <= 1'b0;
        end else if (load1) begin
            a1   <= a;
            b1   <= b;
            bin1 <= bin;
        end
    end

    // Stage 2: low-half result, inter-half carry and the operands the high half needs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_lo2  <= '0;
            c2     <= 1'b0;
            a_hi2  <= '0;
            nb_hi2 <= '0;
            a_msb2 <= 1'b0;
            b_msb2 <= 1'b0;
        end else if (load2) begin
            d_lo2  <= lo_sum;
            c2     <= lo_cout;
            a_hi2  <= a1[WIDTH-1:HALF];
            nb_hi2 <= ~b1[WIDTH-1:HALF];
            a_msb2 <= a1[WIDTH-1];
            b_msb2 <= b1[WIDTH-1];
        end
    end

    // Stage 3: final result; a missing carry out of the top means a borrow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
        end else if (load3) begin
            diff <= {hi_sum, d_lo2};
            bout <= ~hi_cout;
            ovf  <= sub_overflow(a_msb2, b_msb2, hi_sum[HALF-1]);
        end
    end

endmodule

// File: tb/tb_pipelined_lookahead_subtractor.sv
// ---------------------------------------------------------------------------
// tb_pipelined_lookahead_subtractor
// Directed bench for the 64-bit pipelined subtractor.
// ---------------------------------------------------------------------------
module tb_pipelined_lookahead_subtractor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a, b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] diff;
    logic        bout;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    pipelined_lookahead_subtractor #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports every check.
    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            $error("[TB] %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Presents one beat at a negedge; returns after the capturing edge.
    task automatic applyStimulus(input logic [63:0] av, input logic [63:0] bv, input logic bv_in);
        check("in_ready_before_beat", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        bin      = bv_in;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for the result and checks latency and value.
    // Latency counts the capturing edge, so a three-register pipe gives 3.
    task automatic checkOutput(input string tag, input logic [63:0] exp_diff,
                               input logic exp_bout, input logic exp_ovf);
        int edges = 1;
        out_ready = 1'b1;
        while (!out_valid && edges < 12) begin
            @(negedge clk);
            edges++;
        end
        check({tag, "_valid"},   {63'd0, out_valid}, 64'd1);
        check({tag, "_latency"}, 64'(edges), 64'd3);
        check({tag, "_diff"},    diff, exp_diff);
        check({tag, "_bout"},    {63'd0, bout}, {63'd0, exp_bout});
        check({tag, "_ovf"},     {63'd0, ovf},  {63'd0, exp_ovf});
        @(negedge clk);
    endtask

    initial begin
        int sent;
        int received;
        int last_rx;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready",  {63'd0, in_ready},  64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_diff",      diff, 64'd0);
        check("reset_bout",      {63'd0, bout}, 64'd0);
        check("reset_ovf",       {63'd0, ovf},  64'd0);
        out_ready = 1'b1;

        // Directed vectors
        applyStimulus(64'd10, 64'd3, 1'b0);
        checkOutput("basic", 64'd7, 1'b0, 1'b0);
        applyStimulus(64'd0, 64'd1, 1'b1);
        checkOutput("borrow_wrap", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
        applyStimulus(64'h0000_0001_0000_0000, 64'd1, 1'b0);
        checkOutput("inter_half", 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0);
        applyStimulus(64'h8000_0000_0000_0000, 64'd1, 1'b0);
        checkOutput("ovf_neg", 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        checkOutput("ovf_pos", 64'h8000_0000_0000_0000, 1'b1, 1'b1);
        applyStimulus(64'd5, 64'd5, 1'b1);
        checkOutput("equal_bin", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        applyStimulus(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0);
        checkOutput("equal", 64'd0, 1'b0, 1'b0);

        // Back-pressure: 10 beats, consumer stalls during cycles 4..9
        sent     = 0;
        received = 0;
        last_rx  = -1;
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 4 && c <= 9);
            in_valid  = (sent < 10);
            a         = 64'(sent + 100);
            b         = 64'(sent);
            bin       = 1'b0;
            #1;
            if (c == 4)  check("bp_full_in_ready",    {63'd0, in_ready}, 64'd0);
            if (c == 10) check("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
            if (c >= 4 && c <= 9) begin
                check("bp_stall_valid", {63'd0, out_valid}, 64'd1);
                check("bp_stall_diff",  diff, 64'd100);
            end
            if (out_valid && out_ready) begin
                check("bp_diff", diff, 64'd100);
                check("bp_bout", {63'd0, bout}, 64'd0);
                received++;
                last_rx = c;
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("bp_received", 64'(received), 64'd10);
        check("bp_last_cycle", 64'(last_rx), 64'd18);

        // Reset mid-stream with three beats held in the pipe
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = 64'd50;
            b        = 64'd8;
            bin      = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("pre_reset_valid", {63'd0, out_valid}, 64'd1);
        check("pre_reset_diff",  diff, 64'd42);
        check("pre_reset_full",  {63'd0, in_ready}, 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_reset_diff",      diff, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready",  {63'd0, in_ready},  64'd1);
        check("post_reset_out_valid", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b1;
        applyStimulus(64'd1000, 64'd1, 1'b1);
        checkOutput("post_reset_beat", 64'd998, 1'b0, 1'b0);
        @(negedge clk);
        check("post_reset_drained", {63'd0, out_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
